// File: rtl/stream_pkg.sv
// Shared definitions for the stream_master packet streamer.
//   state_e        : LOAD (accepting bytes) / SEND (streaming beats)
//   DATA_W, KEEP_W : beat width in bits and in byte lanes
//   keep_from_cnt  : LSB-contiguous byte-enable mask for a valid-byte count
package stream_pkg;

  localparam int DATA_W = 64;
  localparam int KEEP_W = DATA_W / 8;

  typedef enum logic {
    LOAD = 1'b0,
    SEND = 1'b1
  } state_e;

  // cnt in 0..8 -> (1<<cnt)-1; a 9-bit intermediate lets cnt=8 yield 8'hFF.
  function automatic logic [KEEP_W-1:0] keep_from_cnt(input logic [3:0] cnt);
    logic [KEEP_W:0] one;
    logic [KEEP_W:0] mask;
    one  = (KEEP_W + 1)'(1);
    mask = (one << cnt) - one;
    return mask[KEEP_W-1:0];
  endfunction

endpackage

// File: rtl/stream_buf_ram.sv
// Packet buffer: single-clock RAM, DATA_W bits wide, WORDS deep.
// Ports:
//   clk_i    : clock
//   we_i     : per-byte-lane write enables
//   waddr_i  : write word address
//   wdata_i  : write data (lane k at bits [8k+7:8k])
//   re_i     : read enable; rdata_o updates only when set
//   raddr_i  : read word address
//   rdata_o  : registered read data
// A read of the word being written in the same cycle returns the new lanes,
// so the last byte of a packet can be read back on the edge that stores it.
module stream_buf_ram
  import stream_pkg::*;
#(
  parameter int WORDS = 256,
  parameter int AW    = 8
) (
  input  logic              clk_i,
  input  logic [KEEP_W-1:0] we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [WORDS];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rd_word;

  always_comb begin
    rd_word = mem_q[raddr_i];
    for (int k = 0; k < KEEP_W; k++) begin
      if (we_i[k] && (waddr_i == raddr_i)) begin
        rd_word[8*k +: 8] = wdata_i[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < KEEP_W; k++) begin
      if (we_i[k]) begin
        mem_q[waddr_i][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
    if (re_i) begin
      rdata_q <= rd_word;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/stream_master.sv
// Byte-loaded packet buffer that replays the packet as an AXI-Stream-like
// sequence of 64-bit beats.
// Ports:
//   clk_i, rst_i (async, active-low)
//   wr_valid_i/wr_data_i/wr_last_i/wr_err_i, wr_ready_o : byte load side
//   m_axis_valid_o/data_o/keep_o/vldb_o/sop_o/eop_o/err_o, m_axis_ready_i :
//     beat output side; all outputs come straight from registers.
// Read path: RAM output register (p0) feeds the output register (p1). Word 0
// is read on the edge that accepts the last byte, so the first beat is valid
// one clock after entering SEND, and p0 refills whenever p1 drains.
module stream_master #(
  parameter int DATA_W      = 64,
  parameter int DEPTH_BYTES = 2048
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_valid_i,
  input  logic [7:0]        wr_data_i,
  input  logic              wr_last_i,
  input  logic              wr_err_i,
  output logic              wr_ready_o,
  output logic              m_axis_valid_o,
  output logic [DATA_W-1:0] m_axis_data_o,
  output logic [7:0]        m_axis_keep_o,
  output logic [3:0]        m_axis_vldb_o,
  output logic              m_axis_sop_o,
  output logic              m_axis_eop_o,
  output logic              m_axis_err_o,
  input  logic              m_axis_ready_i
);
  import stream_pkg::*;

  localparam int WORDS = DEPTH_BYTES / 8;
  localparam int AW    = $clog2(WORDS);
  localparam int CW    = $clog2(DEPTH_BYTES) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH_BYTES);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;        // bytes stored; packet length in SEND
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;        // bytes were dropped on overflow
  logic [CW-1:0]     rd_ptr_q, rd_ptr_d;  // next word to read from the RAM
  logic              vld_p0_q, vld_p0_d;
  logic [CW-1:0]     idx_p0_q, idx_p0_d;
  logic              vld_p1_q, vld_p1_d;
  logic [DATA_W-1:0] data_p1_q, data_p1_d;
  logic [7:0]        keep_p1_q, keep_p1_d;
  logic [3:0]        vldb_p1_q, vldb_p1_d;
  logic              sop_p1_q, sop_p1_d;
  logic              eop_p1_q, eop_p1_d;
  logic              err_p1_q, err_p1_d;

  logic [7:0]        ram_we;
  logic [AW-1:0]     ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_re;
  logic [AW-1:0]     ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  logic              accept, full, fire, load_p1, is_last;
  logic [CW-1:0]     nwords, last_word;
  logic [3:0]        vldb_beat;
  logic [7:0]        keep_beat;
  logic [DATA_W-1:0] data_beat;

  stream_buf_ram #(.WORDS(WORDS), .AW(AW)) u_buf (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  assign accept    = (state_q == LOAD) && wr_valid_i;
  assign full      = (cnt_q == DEPTH_C);
  assign nwords    = (cnt_q + CW'(7)) >> 3;
  assign last_word = nwords - CW'(1);
  assign fire      = vld_p1_q && m_axis_ready_i;
  assign load_p1   = (state_q == SEND) && vld_p0_q && (!vld_p1_q || m_axis_ready_i);

  // Beat shaping from the p0 word; tail 0 means a full final word.
  assign is_last   = (idx_p0_q == last_word);
  assign vldb_beat = is_last ? {(cnt_q[2:0] == 3'd0), cnt_q[2:0]} : 4'd8;
  assign keep_beat = keep_from_cnt(vldb_beat);

  always_comb begin
    data_beat = '0;
    for (int k = 0; k < 8; k++) begin
      if (keep_beat[k]) data_beat[8*k +: 8] = ram_rdata[8*k +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    ovf_d     = ovf_q;
    rd_ptr_d  = rd_ptr_q;
    vld_p0_d  = vld_p0_q;
    idx_p0_d  = idx_p0_q;
    vld_p1_d  = vld_p1_q;
    data_p1_d = data_p1_q;
    keep_p1_d = keep_p1_q;
    vldb_p1_d = vldb_p1_q;
    sop_p1_d  = sop_p1_q;
    eop_p1_d  = eop_p1_q;
    err_p1_d  = err_p1_q;
    ram_we    = '0;
    ram_waddr = cnt_q[CW-2:3];
    ram_wdata = {(DATA_W/8){wr_data_i}};
    ram_re    = 1'b0;
    ram_raddr = rd_ptr_q[AW-1:0];

    case (state_q)
      LOAD: begin
        if (accept) begin
          if (!full) begin
            ram_we = 8'b1 << cnt_q[2:0];
            cnt_d  = cnt_q + CW'(1);
          end else begin
            ovf_d = 1'b1;
          end
          if (wr_last_i) begin
            err_d     = wr_err_i || ovf_q || full;
            state_d   = SEND;
            ram_re    = 1'b1;
            ram_raddr = '0;
            vld_p0_d  = 1'b1;
            idx_p0_d  = '0;
            rd_ptr_d  = CW'(1);
          end
        end
      end
      SEND: begin
        if (load_p1) vld_p0_d = 1'b0;
        ram_re = (rd_ptr_q < nwords) && (!vld_p0_q || load_p1);
        if (ram_re) begin
          vld_p0_d = 1'b1;
          idx_p0_d = rd_ptr_q;
          rd_ptr_d = rd_ptr_q + CW'(1);
        end
      end
      default: state_d = LOAD;
    endcase

    if (load_p1) begin
      vld_p1_d  = 1'b1;
      data_p1_d = data_beat;
      keep_p1_d = keep_beat;
      vldb_p1_d = vldb_beat;
      sop_p1_d  = (idx_p0_q == '0);
      eop_p1_d  = is_last;
      err_p1_d  = is_last && err_q;
    end else if (fire) begin
      vld_p1_d  = 1'b0;
      data_p1_d = '0;
      keep_p1_d = '0;
      vldb_p1_d = '0;
      sop_p1_d  = 1'b0;
      eop_p1_d  = 1'b0;
      err_p1_d  = 1'b0;
    end

    if (fire && eop_p1_q) begin
      state_d  = LOAD;
      cnt_d    = '0;
      err_d    = 1'b0;
      ovf_d    = 1'b0;
      rd_ptr_d = '0;
      vld_p0_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= LOAD;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
      rd_ptr_q  <= '0;
      vld_p0_q  <= 1'b0;
      idx_p0_q  <= '0;
      vld_p1_q  <= 1'b0;
      data_p1_q <= '0;
      keep_p1_q <= '0;
      vldb_p1_q <= '0;
      sop_p1_q  <= 1'b0;
      eop_p1_q  <= 1'b0;
      err_p1_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
      rd_ptr_q  <= rd_ptr_d;
      vld_p0_q  <= vld_p0_d;
      idx_p0_q  <= idx_p0_d;
      vld_p1_q  <= vld_p1_d;
      data_p1_q <= data_p1_d;
      keep_p1_q <= keep_p1_d;
      vldb_p1_q <= vldb_p1_d;
      sop_p1_q  <= sop_p1_d;
      eop_p1_q  <= eop_p1_d;
      err_p1_q  <= err_p1_d;
    end
  end

  assign wr_ready_o     = (state_q == LOAD);
  assign m_axis_valid_o = vld_p1_q;
  assign m_axis_data_o  = data_p1_q;
  assign m_axis_keep_o  = keep_p1_q;
  assign m_axis_vldb_o  = vldb_p1_q;
  assign m_axis_sop_o   = sop_p1_q;
  assign m_axis_eop_o   = eop_p1_q;
  assign m_axis_err_o   = err_p1_q;

endmodule

// File: tb/tb_stream_master.sv
module tb_stream_master;

  localparam int DEPTH = 2048;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic [3:0]  v;
    logic        s;
    logic        e;
    logic        r;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        wr_valid_i = 1'b0;
  logic [7:0]  wr_data_i = '0;
  logic        wr_last_i = 1'b0;
  logic        wr_err_i = 1'b0;
  logic        wr_ready_o;
  logic        m_axis_valid_o;
  logic [63:0] m_axis_data_o;
  logic [7:0]  m_axis_keep_o;
  logic [3:0]  m_axis_vldb_o;
  logic        m_axis_sop_o;
  logic        m_axis_eop_o;
  logic        m_axis_err_o;
  logic        m_axis_ready_i = 1'b1;

  int compared = 0;
  int mismatched = 0;
  bit rnd_mode = 1'b0;
  bit in_pkt = 1'b0;

  logic [7:0] pkt [0:DEPTH+15];
  beat_t exp_q [$];
  beat_t got_q [$];
  beat_t t1_q [$];

  stream_master #(.DATA_W(64), .DEPTH_BYTES(DEPTH)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .wr_valid_i     (wr_valid_i),
    .wr_data_i      (wr_data_i),
    .wr_last_i      (wr_last_i),
    .wr_err_i       (wr_err_i),
    .wr_ready_o     (wr_ready_o),
    .m_axis_valid_o (m_axis_valid_o),
    .m_axis_data_o  (m_axis_data_o),
    .m_axis_keep_o  (m_axis_keep_o),
    .m_axis_vldb_o  (m_axis_vldb_o),
    .m_axis_sop_o   (m_axis_sop_o),
    .m_axis_eop_o   (m_axis_eop_o),
    .m_axis_err_o   (m_axis_err_o),
    .m_axis_ready_i (m_axis_ready_i)
  );

  always #5 clk = ~clk;

  // Ready changes just after each rising edge so it is stable at the next one.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_axis_ready_i = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  // Expected beats for an n-byte load of pkt[] from the packet rules alone.
  task automatic build_expect(input int n, input bit err_in);
    int    nb;
    int    beats;
    beat_t b;
    nb    = (n > DEPTH) ? DEPTH : n;
    beats = (nb + 7) / 8;
    for (int w = 0; w < beats; w++) begin
      b = '0;
      for (int l = 0; l < 8; l++) begin
        if (w * 8 + l < nb) begin
          b.d[8*l +: 8] = pkt[w * 8 + l];
          b.k[l]        = 1'b1;
          b.v           = b.v + 4'd1;
        end
      end
      b.s = (w == 0);
      b.e = (w == beats - 1);
      b.r = b.e && (err_in || (n > DEPTH));
      exp_q.push_back(b);
    end
  endtask

  // Compare process: every falling edge while out of reset.
  beat_t act, prev, want;
  bit    prev_v, prev_r;
  initial begin
    prev_v = 1'b0;
    prev_r = 1'b0;
    prev   = '0;
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        prev_v = 1'b0;
        in_pkt = 1'b0;
      end else begin
        act = {m_axis_data_o, m_axis_keep_o, m_axis_vldb_o,
               m_axis_sop_o, m_axis_eop_o, m_axis_err_o};
        if (prev_v && !prev_r) begin
          compared++;
          if (!m_axis_valid_o || act !== prev) begin
            mismatched++;
            $display("FAIL stall_hold: got v=%b %h want v=1 %h", m_axis_valid_o, act, prev);
          end
        end
        if (m_axis_valid_o) begin
          if (m_axis_ready_i) begin
            compared++;
            if (exp_q.size() == 0) begin
              mismatched++;
              $display("FAIL extra_beat: got %h want no beat", act);
            end else begin
              want = exp_q.pop_front();
              if (act !== want) begin
                mismatched++;
                $display("FAIL beat: got d=%h k=%h v=%0d s%b e%b r%b want d=%h k=%h v=%0d s%b e%b r%b",
                         act.d, act.k, act.v, act.s, act.e, act.r,
                         want.d, want.k, want.v, want.s, want.e, want.r);
              end
            end
            got_q.push_back(act);
            if (m_axis_sop_o) in_pkt = 1'b1;
            if (m_axis_eop_o) in_pkt = 1'b0;
          end
        end else begin
          compared++;
          if (act !== '0 || (in_pkt && !rnd_mode)) begin
            mismatched++;
            $display("FAIL idle: got %h in_pkt=%b want 0 and no gap", act, in_pkt);
          end
        end
        prev_v = m_axis_valid_o;
        prev_r = m_axis_ready_i;
        prev   = act;
      end
    end
  end

  // Called at a falling edge; each byte is taken at the following rising edge.
  task automatic load_pkt(input int n, input bit err_in, input bit gaps);
    build_expect(n, err_in);
    chk("wr_ready_load", 64'(wr_ready_o), 64'd1);
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 3 == 2)) begin
        wr_valid_i = 1'b0;
        @(negedge clk);
      end
      wr_valid_i = 1'b1;
      wr_data_i  = pkt[i];
      wr_last_i  = (i == n - 1);
      wr_err_i   = err_in && (i == n - 1);
      @(negedge clk);
    end
    wr_valid_i = 1'b0;
    wr_last_i  = 1'b0;
    wr_err_i   = 1'b0;
    chk("send_entry_valid", 64'(m_axis_valid_o), 64'd0);
    chk("send_wr_ready", 64'(wr_ready_o), 64'd0);
    @(negedge clk);
    chk("first_beat_latency", 64'(m_axis_valid_o), 64'd1);
  endtask

  // Optionally hammers the load port with junk while the packet drains.
  task automatic wait_done(input bit junk);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      if (exp_q.size() == 0 && !m_axis_valid_o) begin
        done = 1'b1;
        break;
      end
      wr_valid_i = junk;
      wr_last_i  = junk;
      wr_data_i  = 8'hA5;
      @(negedge clk);
    end
    wr_valid_i = 1'b0;
    wr_last_i  = 1'b0;
    chk("packet_done", 64'(done), 64'd1);
  endtask

  initial begin
    logic [63:0] first8;
    bit          all_ff;
    bit          seen;

    // Reset state
    #23;
    chk("rst_valid", 64'(m_axis_valid_o), 64'd0);
    chk("rst_outs", {m_axis_data_o} | 64'(m_axis_keep_o) | 64'(m_axis_vldb_o), 64'd0);
    @(negedge clk);
    rst_i = 1'b1;
    chk("rst_wr_ready", 64'(wr_ready_o), 64'd1);

    // 61 bytes, ready tied high
    first8 = 64'hec8c9d5b62125b84;
    for (int i = 0; i < 8; i++) pkt[i] = first8[8*i +: 8];
    for (int i = 8; i < 61; i++) pkt[i] = 8'(i * 7 + 3);
    got_q.delete();
    load_pkt(61, 1'b0, 1'b0);
    wait_done(1'b0);
    chk("t1_beats", 64'(got_q.size()), 64'd8);
    if (got_q.size() == 8) begin
      chk("t1_b0_data", got_q[0].d, 64'hec8c9d5b62125b84);
      chk("t1_b0_sop", 64'(got_q[0].s), 64'd1);
      chk("t1_b7_keep", 64'(got_q[7].k), 64'h1F);
      chk("t1_b7_vldb", 64'(got_q[7].v), 64'd5);
      chk("t1_b7_eop_err", {62'd0, got_q[7].e, got_q[7].r}, 64'b10);
    end
    t1_q = got_q;

    // 64 bytes, with idle cycles in the load stream
    for (int i = 0; i < 64; i++) pkt[i] = 8'(255 - i);
    got_q.delete();
    load_pkt(64, 1'b0, 1'b1);
    wait_done(1'b0);
    chk("t2_beats", 64'(got_q.size()), 64'd8);
    all_ff = 1'b1;
    foreach (got_q[i]) if (got_q[i].k != 8'hFF) all_ff = 1'b0;
    chk("t2_keep_ff", 64'(all_ff), 64'd1);
    if (got_q.size() == 8) begin
      chk("t2_b7_eop_vldb", {59'd0, got_q[7].e, got_q[7].v}, {59'd0, 1'b1, 4'd8});
      chk("t2_b0_data", got_q[0].d, 64'hf8f9fafbfcfdfeff);
    end

    // 1 byte, errored
    pkt[0] = 8'h3C;
    got_q.delete();
    load_pkt(1, 1'b1, 1'b0);
    wait_done(1'b0);
    chk("t3_beats", 64'(got_q.size()), 64'd1);
    if (got_q.size() == 1) begin
      chk("t3_sop_eop_err", {61'd0, got_q[0].s, got_q[0].e, got_q[0].r}, 64'b111);
      chk("t3_keep", 64'(got_q[0].k), 64'h01);
      chk("t3_data", got_q[0].d, 64'h3C);
    end

    // 61 bytes again under random back-pressure, junk on the load port
    for (int i = 0; i < 8; i++) pkt[i] = first8[8*i +: 8];
    for (int i = 8; i < 61; i++) pkt[i] = 8'(i * 7 + 3);
    got_q.delete();
    rnd_mode = 1'b1;
    load_pkt(61, 1'b0, 1'b0);
    wait_done(1'b1);
    rnd_mode = 1'b0;
    chk("t4_beats", 64'(got_q.size()), 64'(t1_q.size()));
    if (got_q.size() == t1_q.size()) begin
      foreach (got_q[i]) chk("t4_same_seq", 64'(got_q[i] == t1_q[i]), 64'd1);
    end

    // Reset mid-SEND, then a clean 16-byte packet
    for (int i = 0; i < 61; i++) pkt[i] = 8'(i + 8'h80);
    got_q.delete();
    load_pkt(61, 1'b0, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (got_q.size() >= 3) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("t5_started", 64'(seen), 64'd1);
    @(posedge clk);
    #2;
    rst_i = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(m_axis_valid_o), 64'd0);
    chk("t5_rst_outs", m_axis_data_o | 64'(m_axis_keep_o) | 64'(m_axis_eop_o), 64'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    got_q.delete();
    rst_i = 1'b1;
    for (int i = 0; i < 16; i++) pkt[i] = 8'(8'h10 + i);
    load_pkt(16, 1'b0, 1'b0);
    wait_done(1'b0);
    chk("t5_beats", 64'(got_q.size()), 64'd2);
    if (got_q.size() == 2) begin
      chk("t5_b0_data", got_q[0].d, 64'h1716151413121110);
      chk("t5_b1_data", got_q[1].d, 64'h1f1e1d1c1b1a1918);
      chk("t5_b1_keep_eop", {55'd0, got_q[1].k, got_q[1].e}, {55'd0, 8'hFF, 1'b1});
    end

    // Overflow: DEPTH+5 bytes
    for (int i = 0; i < DEPTH + 5; i++) pkt[i] = 8'(i ^ (i >> 8));
    got_q.delete();
    load_pkt(DEPTH + 5, 1'b0, 1'b0);
    wait_done(1'b0);
    chk("t6_beats", 64'(got_q.size()), 64'(DEPTH / 8));
    if (got_q.size() == DEPTH / 8) begin
      chk("t6_last_keep", 64'(got_q[DEPTH/8-1].k), 64'hFF);
      chk("t6_last_err_eop", {62'd0, got_q[DEPTH/8-1].e, got_q[DEPTH/8-1].r}, 64'b11);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
